stimulus_sequencer: RTL and testbench

- Generates the 3-bit test-vector stream that feeds the lab decoder/OR function stage.
- Replaces the bare free-running prescaler-plus-counter pair with a controlled source. It has a prescaled auto-run mode, a debounced single-step mode from a board push-button, a per-vector strobe and a sticky full-sweep flag.
- Outputs drive the decoder data input directly; the strobe and flag go to board LEDs.

---
 rtl/stimulus_sequencer_pkg.sv | 17 +
 rtl/stimulus_sequencer_if.sv | 33 +++
 rtl/stimulus_sequencer_key_debouncer.sv | 58 +++++
 rtl/stimulus_sequencer.sv | 106 ++++++++++
 tb/tb_stimulus_sequencer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/stimulus_sequencer_pkg.sv
// Shared encodings and default widths for the stimulus sequencer and its
// debouncer.
package stimulus_sequencer_pkg;

    localparam logic ST_STEP = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int VEC_WIDTH_DEF      = 3;
    localparam int PRESCALE_WIDTH_DEF = 25;
    localparam int DEBOUNCE_WIDTH_DEF = 16;

    typedef enum logic {
        S_STEP = ST_STEP,
        S_RUN  = ST_RUN
    } state_e;

endpackage

// File: rtl/stimulus_sequencer_if.sv
// Output bundle of the sequencer: vector stream, strobe, sweep flag, prescaler
// tick and the mode state.
interface stimulus_sequencer_if
    import stimulus_sequencer_pkg::*;
#(
    parameter int VEC_WIDTH = VEC_WIDTH_DEF
) ();

    // vec_valid is a strobe with no back-pressure: it is high for exactly the
    // first cycle a new x_vec is visible, and the consumer must take it then.
    logic [VEC_WIDTH-1:0] x_vec;
    logic                 vec_valid;
    logic                 sweep_done;
    logic                 tick;
    state_e               state;

    modport master (
        output x_vec,
        output vec_valid,
        output sweep_done,
        output tick,
        output state
    );

    modport slave (
        input x_vec,
        input vec_valid,
        input sweep_done,
        input tick,
        input state
    );

endinterface

// File: rtl/stimulus_sequencer_key_debouncer.sv
// Push-button front end: 2-FF synchroniser, stability counter and a
// one-cycle press event on the debounced released->pressed edge.
module key_debouncer #(
    parameter int DEBOUNCE_WIDTH = 16
) (
    input  logic clock,
    input  logic rst_n,
    input  logic key_n,
    output logic press_evt
);

    // The flip happens on the edge that would take the counter to all-ones,
    // i.e. after 2^DEBOUNCE_WIDTH-1 consecutive mismatching cycles.
    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST =
        {DEBOUNCE_WIDTH{1'b1}} - DEBOUNCE_WIDTH'(1);

    logic                      key_meta_q, key_meta_d;
    logic                      key_sync_q, key_sync_d;
    logic                      stable_q,   stable_d;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q,      cnt_d;
    logic                      press_q,    press_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            stable_q   <= 1'b1;
            cnt_q      <= '0;
            press_q    <= 1'b0;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
        end
    end

    always_comb begin
        key_meta_d = key_n;
        key_sync_d = key_meta_q;
        stable_d   = stable_q;
        cnt_d      = '0;
        press_d    = 1'b0;
        if (key_sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = key_sync_q;
                // Only the 1->0 (press) edge of the stable level is reported.
                press_d  = stable_q;
            end else begin
                cnt_d = cnt_q + DEBOUNCE_WIDTH'(1);
            end
        end
    end

    assign press_evt = press_q;

endmodule

// File: rtl/stimulus_sequencer.sv
// Test-vector source for the decoder stage: prescaled auto-run or debounced
// single-step counting, with a per-vector strobe and a sticky sweep flag.
module stimulus_sequencer
    import stimulus_sequencer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
    parameter int VEC_WIDTH      = VEC_WIDTH_DEF,
    parameter int DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  run_sw,
    input  logic                  key_n,
    stimulus_sequencer_if.master  vec_if
);

    logic                      run_meta_q, run_meta_d;
    logic                      run_sync_q, run_sync_d;
    logic [PRESCALE_WIDTH-1:0] presc_q,    presc_d;
    state_e                    state_q,    state_d;
    logic [VEC_WIDTH-1:0]      x_q,        x_d;
    logic                      valid_q,    valid_d;
    logic                      sweep_q,    sweep_d;

    logic press_evt;
    logic tick_w;
    logic inc;

    key_debouncer #(
        .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
    ) u_key_debouncer (
        .clock     (clock),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .press_evt (press_evt)
    );

    assign tick_w = &presc_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            run_meta_q <= 1'b0;
            run_sync_q <= 1'b0;
            presc_q    <= '0;
            state_q    <= S_STEP;
            x_q        <= '0;
            valid_q    <= 1'b0;
            sweep_q    <= 1'b0;
        end else begin
            run_meta_q <= run_meta_d;
            run_sync_q <= run_sync_d;
            presc_q    <= presc_d;
            state_q    <= state_d;
            x_q        <= x_d;
            valid_q    <= valid_d;
            sweep_q    <= sweep_d;
        end
    end

    // A mode transition suppresses the tick/press of the same cycle.
    always_comb begin
        run_meta_d = run_sw;
        run_sync_d = run_meta_q;
        presc_d    = presc_q + PRESCALE_WIDTH'(1);
        state_d    = state_q;
        x_d        = x_q;
        valid_d    = 1'b0;
        sweep_d    = sweep_q;
        inc        = 1'b0;
        case (state_q)
            S_STEP: begin
                if (run_sync_q) begin
                    state_d = S_RUN;
                    presc_d = '0;
                    sweep_d = 1'b0;
                end else begin
                    inc = press_evt;
                end
            end
            S_RUN: begin
                if (!run_sync_q) begin
                    state_d = S_STEP;
                end else begin
                    inc = tick_w;
                end
            end
            default: begin
                state_d = S_STEP;
            end
        endcase
        if (inc) begin
            x_d     = x_q + VEC_WIDTH'(1);
            valid_d = 1'b1;
            if ((state_q == S_RUN) && (&x_q)) begin
                sweep_d = 1'b1;
            end
        end
    end

    assign vec_if.x_vec      = x_q;
    assign vec_if.vec_valid  = valid_q;
    assign vec_if.sweep_done = sweep_q;
    assign vec_if.tick       = tick_w;
    assign vec_if.state      = state_q;

endmodule

// File: tb/tb_stimulus_sequencer.sv
// Directed bench for stimulus_sequencer with PRESCALE_WIDTH=3, DEBOUNCE_WIDTH=2.
module tb_stimulus_sequencer;
  import stimulus_sequencer_pkg::*;

  localparam int VW = 3;

  logic clock = 1'b0;
  logic rst_n;
  logic run_sw;
  logic key_n;

  stimulus_sequencer_if #(.VEC_WIDTH(VW)) vec_if ();

  stimulus_sequencer #(
    .PRESCALE_WIDTH (3),
    .VEC_WIDTH      (VW),
    .DEBOUNCE_WIDTH (2)
  ) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .run_sw (run_sw),
    .key_n  (key_n),
    .vec_if (vec_if)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic          run_sw;
    logic          key_n;
    int            adv;
    logic [VW-1:0] exp_x;
    logic          exp_valid;
    logic          exp_sweep;
    logic          chk_tick;
    logic          exp_tick;
    int            exp_pulses;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  function automatic vec_t mk(logic r, logic k, int a, logic [VW-1:0] x, logic v,
                              logic s, logic ct, logic t, int p);
    vec_t e;
    e.run_sw = r; e.key_n = k; e.adv = a; e.exp_x = x; e.exp_valid = v;
    e.exp_sweep = s; e.chk_tick = ct; e.exp_tick = t; e.exp_pulses = p;
    return e;
  endfunction

  // scoreboard compare
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver: advance n rising edges, sampling 1ns after each
  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (vec_if.vec_valid === 1'b1) pulse_cnt++;
    end
  endtask

  task automatic check_outs(string tag, logic [VW-1:0] x, logic v, logic s);
    check({tag, "_x"}, 32'(vec_if.x_vec), 32'(x));
    check({tag, "_valid"}, 32'(vec_if.vec_valid), 32'(v));
    check({tag, "_sweep"}, 32'(vec_if.sweep_done), 32'(s));
  endtask

  initial begin
    // RUN sweep from reset release (edge indices counted from release)
    tbl.push_back(mk(1, 1, 3,  3'd0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 7,  3'd0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1,  3'd1, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1,  3'd1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 7,  3'd2, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 40, 3'd7, 1, 0, 1, 0, 5));
    tbl.push_back(mk(1, 1, 7,  3'd7, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1,  3'd0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1,  3'd0, 0, 1, 1, 0, 0));
    // back to STEP, one long press then release
    tbl.push_back(mk(0, 1, 3,  3'd0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 10, 3'd0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 5,  3'd0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  3'd1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4,  3'd1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 10, 3'd1, 0, 1, 0, 0, 0));
    // bounce: low 2, high 1, low 2, high
    tbl.push_back(mk(0, 0, 2,  3'd1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1,  3'd1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2,  3'd1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8,  3'd1, 0, 1, 0, 0, 0));
    // four clean presses up to x_vec=5
    for (int p = 2; p <= 5; p++) begin
      tbl.push_back(mk(0, 0, 6, 3'(p), 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 6, 3'(p), 0, 1, 0, 0, 0));
    end

    // reset state
    rst_n = 1'b1; run_sw = 1'b0; key_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_outs("reset", 3'd0, 1'b0, 1'b0);
    check("reset_tick", 32'(vec_if.tick), 32'd0);
    check("reset_state", 32'(vec_if.state), 32'(ST_STEP));
    step(2);
    run_sw = 1'b1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_sw = tbl[i].run_sw;
      key_n = tbl[i].key_n;
      pulse_cnt = 0;
      step(tbl[i].adv);
      check_outs($sformatf("row%0d", i), tbl[i].exp_x, tbl[i].exp_valid, tbl[i].exp_sweep);
      check($sformatf("row%0d_pulses", i), 32'(pulse_cnt), 32'(tbl[i].exp_pulses));
      if (tbl[i].chk_tick) check($sformatf("row%0d_tick", i), 32'(vec_if.tick), 32'(tbl[i].exp_tick));
    end

    // STEP->RUN in the same cycle as a press event: transition wins
    key_n = 1'b0;
    step(3);
    run_sw = 1'b1;
    step(2);
    check_outs("simul_pre", 3'd5, 1'b0, 1'b1);
    check("simul_pre_state", 32'(vec_if.state), 32'(ST_STEP));
    step(1);
    check_outs("simul_entry", 3'd5, 1'b0, 1'b0);
    check("simul_entry_state", 32'(vec_if.state), 32'(ST_RUN));
    key_n = 1'b1;
    step(7);
    check_outs("simul_hold", 3'd5, 1'b0, 1'b0);
    check("simul_hold_tick", 32'(vec_if.tick), 32'd1);
    step(1);
    check_outs("simul_first", 3'd6, 1'b1, 1'b0);

    // run on to x_vec=4 with sweep_done set, bounded wait
    begin
      int budget = 100;
      while (budget > 0 && !(vec_if.x_vec === 3'd4 && vec_if.sweep_done === 1'b1)) begin
        step(1);
        budget--;
      end
      check("wait_x4_sweep_timeout", 32'(budget > 0), 32'd1);
    end

    // asynchronous reset mid-RUN
    #3 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 3'd0, 1'b0, 1'b0);
    check("async_rst_tick", 32'(vec_if.tick), 32'd0);
    check("async_rst_state", 32'(vec_if.state), 32'(ST_STEP));
    step(1);
    rst_n = 1'b1;
    step(2);
    check("resume_e2_state", 32'(vec_if.state), 32'(ST_STEP));
    step(1);
    check("resume_e3_state", 32'(vec_if.state), 32'(ST_RUN));
    check_outs("resume_e3", 3'd0, 1'b0, 1'b0);
    step(7);
    check("resume_tick", 32'(vec_if.tick), 32'd1);
    step(1);
    check_outs("resume_first", 3'd1, 1'b1, 1'b0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
